// File: rtl/muldiv_ctrl_pkg.sv
// common: shared HI/LO write-request and mul/div operation types, FSM states, divider constants
package common;

    localparam int DIV_ITERS = 32;

    typedef enum logic [3:0] {
        MULT, MULTU, DIV, DIVU, MTHI, MTLO, MADD, MADDU, MSUB, MSUBU
    } muldiv_op_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } hilo_write_req;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} muldiv_state_t;

    function automatic logic op_signed(muldiv_op_t op);
        return op inside {MULT, DIV, MADD, MSUB};
    endfunction

    function automatic logic op_is_mul(muldiv_op_t op);
        return op inside {MULT, MULTU};
    endfunction

    function automatic logic op_is_div(muldiv_op_t op);
        return op inside {DIV, DIVU};
    endfunction

    function automatic logic op_is_acc(muldiv_op_t op);
        return op inside {MADD, MADDU, MSUB, MSUBU};
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// div_iter: unsigned restoring divider, one quotient bit per cycle, DIV_ITERS iterations
module div_iter
    import common::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);

    logic [31:0] dvs;
    logic [5:0]  cnt;
    logic [32:0] shifted;
    logic [32:0] diff;

    assign shifted = {remainder, quotient[31]};
    assign diff    = shifted - {1'b0, dvs};
    assign done    = cnt == 6'd1;

    // load on start, then one shift/trial-subtract step per cycle until the count runs out
    always_ff @(posedge clk) begin
        if (reset) begin
            quotient  <= '0;
            remainder <= '0;
            dvs       <= '0;
            cnt       <= '0;
        end else if (abort) begin
            cnt <= '0;
        end else if (start) begin
            quotient  <= dividend;
            remainder <= '0;
            dvs       <= divisor;
            cnt       <= 6'(DIV_ITERS);
        end else if (cnt != '0) begin
            remainder <= diff[32] ? shifted[31:0] : diff[31:0];
            quotient  <= {quotient[30:0], !diff[32]};
            cnt       <= cnt - 6'd1;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO multiply/divide sequencer; MADD/MSUB accumulate enabled by MULDIV_MADD_EN
module muldiv_ctrl
    import common::*;
#(
    parameter int MUL_CYCLES = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  muldiv_op_t    req_op,
    input  logic [31:0]   src_a,
    input  logic [31:0]   src_b,
    input  logic [31:0]   hi_in,
    input  logic [31:0]   lo_in,
    input  logic          flush,
    output logic          busy,
    output hilo_write_req hi_req,
    output hilo_write_req lo_req
);

    muldiv_state_t state, next_state, entry_state;
    muldiv_op_t    op_q;
    logic [31:0]   a_q, b_q;
    logic [2:0]    cnt;
    logic          accept, div_done, fire, wr_hi, wr_lo;
    logic [31:0]   a_mag, b_mag, quo, rem, q_fix, r_fix;
    logic [63:0]   ext_a, ext_b, product, div_res, acc_res, result;

`ifdef MULDIV_MADD_EN
    localparam bit MADD_EN = 1'b1;
    logic [31:0] hi_q, lo_q;

    // capture the HI/LO accumulator base at acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (accept) begin
            hi_q <= hi_in;
            lo_q <= lo_in;
        end
    end

    assign acc_res = (op_q == MSUB || op_q == MSUBU) ? {hi_q, lo_q} - product : {hi_q, lo_q} + product;
`else
    localparam bit MADD_EN = 1'b0;
    logic unused_acc;

    assign unused_acc = ^{hi_in, lo_in};
    assign acc_res    = '0;
`endif

    assign req_ready   = state == S_IDLE && !flush && !reset;
    assign busy        = state != S_IDLE && !reset;
    assign accept      = req_valid && req_ready;
    assign entry_state = (op_is_mul(req_op) || (MADD_EN && op_is_acc(req_op))) ? ((MUL_CYCLES == 1) ? S_DONE : S_MUL)
                       : op_is_div(req_op) ? S_DIV : S_DONE;

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // next-state logic; flush always returns to idle
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  next_state = accept ? entry_state : S_IDLE;
            S_MUL:   next_state = (cnt <= 3'd1) ? S_DONE : S_MUL;
            S_DIV:   next_state = div_done ? S_DONE : S_DIV;
            default: next_state = S_IDLE;
        endcase
        if (flush) next_state = S_IDLE;
    end

    // latch the operation at acceptance and count down the multiply latency
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q <= MULT;
            a_q  <= '0;
            b_q  <= '0;
            cnt  <= '0;
        end else if (accept) begin
            op_q <= req_op;
            a_q  <= src_a;
            b_q  <= src_b;
            cnt  <= 3'(MUL_CYCLES - 1);
        end else if (state == S_MUL && cnt != '0) begin
            cnt <= cnt - 3'd1;
        end
    end

    assign ext_a   = op_signed(op_q) ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    assign ext_b   = op_signed(op_q) ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    assign product = ext_a * ext_b;

    assign a_mag = (op_signed(req_op) && src_a[31]) ? -src_a : src_a;
    assign b_mag = (op_signed(req_op) && src_b[31]) ? -src_b : src_b;

    div_iter u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (accept && op_is_div(req_op)),
        .abort     (flush),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo),
        .remainder (rem),
        .done      (div_done)
    );

    assign q_fix   = (op_q == DIV && (a_q[31] ^ b_q[31])) ? -quo : quo;
    assign r_fix   = (op_q == DIV && a_q[31]) ? -rem : rem;
    assign div_res = (b_q == '0) ? {a_q, 32'hFFFF_FFFF} : {r_fix, q_fix};

    // per-operation result and which halves get written
    always_comb begin
        result = acc_res;
        wr_hi  = MADD_EN;
        wr_lo  = MADD_EN;
        case (op_q)
            MTHI:        begin result = {a_q, 32'b0}; wr_hi = 1'b1; wr_lo = 1'b0; end
            MTLO:        begin result = {32'b0, a_q}; wr_hi = 1'b0; wr_lo = 1'b1; end
            MULT, MULTU: begin result = product;      wr_hi = 1'b1; wr_lo = 1'b1; end
            DIV, DIVU:   begin result = div_res;      wr_hi = 1'b1; wr_lo = 1'b1; end
            default:     ;
        endcase
    end

    // write requests fire only in DONE, suppressed by flush or reset
    always_comb begin
        fire         = state == S_DONE && !flush && !reset;
        hi_req.valid = fire && wr_hi;
        hi_req.data  = result[63:32];
        lo_req.valid = fire && wr_lo;
        lo_req.data  = result[31:0];
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: self-checking bench for muldiv_ctrl with a behavioural HI/LO reference model
module tb_muldiv_ctrl;
    import common::*;

    localparam int MC = 3;

    logic          clk = 1'b0, reset = 1'b1, req_valid = 1'b0, flush = 1'b0;
    logic          req_ready, busy;
    muldiv_op_t    req_op = MULT;
    logic [31:0]   src_a = '0, src_b = '0, hi_in = '0, lo_in = '0;
    hilo_write_req hi_req, lo_req;

    int          errors = 0, checks = 0;
    int          o_lat, o_nval, o_nbusy, o_rdy;
    logic        o_hv, o_lv, o_ev_busy, o_ev_rdy, issue_rdy;
    logic [31:0] o_hd, o_ld;

    muldiv_ctrl #(.MUL_CYCLES(MC)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .src_a(src_a), .src_b(src_b), .hi_in(hi_in), .lo_in(lo_in), .flush(flush),
        .busy(busy), .hi_req(hi_req), .lo_req(lo_req)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model(input muldiv_op_t op, input logic [31:0] a, b, h, l,
                                  output logic wh, wl, output logic [31:0] eh, el, output int lat);
        longint      sa, sb;
        logic [63:0] p, acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == MULTU || op == MADDU || op == MSUBU) p = {32'b0, a} * {32'b0, b};
        else p = sa * sb;
        acc = '0;
        wh = 0; wl = 0; eh = '0; el = '0; lat = 1;
        case (op)
            MULT, MULTU: begin wh = 1; wl = 1; {eh, el} = p; lat = MC; end
            DIV: begin
                wh = 1; wl = 1; lat = 33;
                if (b == 0) begin eh = a; el = 32'hFFFF_FFFF; end
                else begin el = 32'(sa / sb); eh = 32'(sa % sb); end
            end
            DIVU: begin
                wh = 1; wl = 1; lat = 33;
                if (b == 0) begin eh = a; el = 32'hFFFF_FFFF; end
                else begin el = a / b; eh = a % b; end
            end
            MTHI: begin wh = 1; eh = a; end
            MTLO: begin wl = 1; el = a; end
            default: begin
`ifdef MULDIV_MADD_EN
                acc = (op == MSUB || op == MSUBU) ? {h, l} - p : {h, l} + p;
                wh = 1; wl = 1; {eh, el} = acc; lat = MC;
`endif
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input muldiv_op_t op, input logic [31:0] a, b, h, l);
        @(negedge clk);
        req_op = op; src_a = a; src_b = b; hi_in = h; lo_in = l; req_valid = 1;
        #1 issue_rdy = req_ready;
        @(posedge clk);
        #1 req_valid = 0;
        req_op = muldiv_op_t'($urandom_range(0, 9));
        src_a = $urandom; src_b = $urandom; hi_in = $urandom; lo_in = $urandom;
    endtask

    task automatic observe(input int max, input int flush_at, input int reset_at, input int ev_at);
        o_lat = 0; o_nval = 0; o_nbusy = 0; o_rdy = 0;
        o_hv = 0; o_lv = 0; o_hd = '0; o_ld = '0; o_ev_busy = 0; o_ev_rdy = 0;
        for (int c = 1; c <= max; c++) begin
            @(negedge clk);
            flush = (c == flush_at);
            reset = (c == reset_at);
            #1;
            if (c == ev_at) begin o_ev_busy = busy; o_ev_rdy = req_ready; end
            if (busy) o_nbusy++;
            if (hi_req.valid || lo_req.valid) begin
                o_nval++;
                if (o_lat == 0) begin
                    o_lat = c; o_hv = hi_req.valid; o_hd = hi_req.data; o_lv = lo_req.valid; o_ld = lo_req.data;
                end
            end
            if (req_ready && o_rdy == 0) o_rdy = c;
        end
        flush = 0;
        reset = 0;
    endtask

    task automatic test_reset();
        req_valid = 1; req_op = MTLO; src_a = 32'h55;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", req_ready); end
        checks++; if ((hi_req.valid | lo_req.valid) !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b%b want 00", hi_req.valid, lo_req.valid); end
        reset = 0; req_valid = 0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy: got %b want 0", busy); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", req_ready); end
        checks++; if ((hi_req.valid | lo_req.valid) !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %b%b want 00", hi_req.valid, lo_req.valid); end
        observe(3, 0, 0, 0);
        checks++; if (o_nval + o_nbusy !== 0) begin errors++; $display("FAIL post_rst_idle: got valid=%0d busy=%0d want 0 0", o_nval, o_nbusy); end
    endtask

    task automatic test_mult();
        muldiv_op_t  ops [2];
        logic [31:0] eh [2], el [2];
        ops = '{MULT, MULTU}; eh = '{32'hFFFF_FFFF, 32'h1}; el = '{32'hFFFF_FFFE, 32'hFFFF_FFFE};
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], 32'hFFFF_FFFF, 32'h2, 0, 0);
            observe(MC + 3, 0, 0, 0);
            checks++; if (issue_rdy !== 1'b1) begin errors++; $display("FAIL mult%0d_ready: got %b want 1", i, issue_rdy); end
            checks++; if (o_lat !== MC) begin errors++; $display("FAIL mult%0d_latency: got %0d want %0d", i, o_lat, MC); end
            checks++; if (o_nval !== 1) begin errors++; $display("FAIL mult%0d_valid_cycles: got %0d want 1", i, o_nval); end
            checks++; if ({o_hv, o_lv} !== 2'b11) begin errors++; $display("FAIL mult%0d_valids: got %b%b want 11", i, o_hv, o_lv); end
            checks++; if (o_hd !== eh[i]) begin errors++; $display("FAIL mult%0d_hi: got %h want %h", i, o_hd, eh[i]); end
            checks++; if (o_ld !== el[i]) begin errors++; $display("FAIL mult%0d_lo: got %h want %h", i, o_ld, el[i]); end
        end
    endtask

    task automatic test_div();
        muldiv_op_t  ops [3];
        logic [31:0] as [3], bs [3], eh [3], el [3];
        ops = '{DIV, DIVU, DIV};
        as = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
        bs = '{32'd2, 32'd0, 32'hFFFF_FFFF};
        eh = '{32'hFFFF_FFFF, 32'd7, 32'd0};
        el = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], as[i], bs[i], 0, 0);
            observe(36, 0, 0, 0);
            checks++; if (o_lat !== 33) begin errors++; $display("FAIL div%0d_latency: got %0d want 33", i, o_lat); end
            checks++; if ({o_hv, o_lv} !== 2'b11) begin errors++; $display("FAIL div%0d_valids: got %b%b want 11", i, o_hv, o_lv); end
            checks++; if (o_hd !== eh[i]) begin errors++; $display("FAIL div%0d_hi: got %h want %h", i, o_hd, eh[i]); end
            checks++; if (o_ld !== el[i]) begin errors++; $display("FAIL div%0d_lo: got %h want %h", i, o_ld, el[i]); end
        end
    endtask

    task automatic test_move();
        issue(MTLO, 32'h1234, 0, 0, 0);
        observe(3, 0, 0, 0);
        checks++; if (o_lat !== 1) begin errors++; $display("FAIL mtlo_latency: got %0d want 1", o_lat); end
        checks++; if ({o_hv, o_lv} !== 2'b01) begin errors++; $display("FAIL mtlo_valids: got %b%b want 01", o_hv, o_lv); end
        checks++; if (o_ld !== 32'h1234) begin errors++; $display("FAIL mtlo_lo: got %h want 00001234", o_ld); end
        checks++; if (o_nbusy !== 1) begin errors++; $display("FAIL mtlo_busy: got %0d want 1", o_nbusy); end
        issue(MTHI, 32'hCAFE_F00D, 0, 0, 0);
        observe(3, 0, 0, 0);
        checks++; if ({o_hv, o_lv} !== 2'b10) begin errors++; $display("FAIL mthi_valids: got %b%b want 10", o_hv, o_lv); end
        checks++; if (o_hd !== 32'hCAFE_F00D) begin errors++; $display("FAIL mthi_hi: got %h want cafef00d", o_hd); end
    endtask

    task automatic test_accum();
        issue(MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF);
        observe(MC + 3, 0, 0, 0);
`ifdef MULDIV_MADD_EN
        checks++; if (o_lat !== MC) begin errors++; $display("FAIL maddu_latency: got %0d want %0d", o_lat, MC); end
        checks++; if (o_hd !== 32'd1) begin errors++; $display("FAIL maddu_hi: got %h want 1", o_hd); end
        checks++; if (o_ld !== 32'd0) begin errors++; $display("FAIL maddu_lo: got %h want 0", o_ld); end
`else
        checks++; if (o_nval !== 0) begin errors++; $display("FAIL maddu_nowrite: got %0d valid cycles want 0", o_nval); end
        checks++; if (o_nbusy !== 1) begin errors++; $display("FAIL maddu_busy: got %0d want 1", o_nbusy); end
`endif
    endtask

    task automatic test_flush();
        issue(DIV, 32'd100, 32'd7, 0, 0);
        observe(40, 10, 0, 0);
        checks++; if (o_nval !== 0) begin errors++; $display("FAIL flush_div_nowrite: got %0d want 0", o_nval); end
        checks++; if (o_rdy !== 11) begin errors++; $display("FAIL flush_div_ready: got %0d want 11", o_rdy); end
        issue(MULT, 32'd6, 32'd7, 0, 0);
        observe(MC + 2, 0, 0, 0);
        checks++; if (o_lat !== MC || o_ld !== 32'd42 || o_hd !== 32'd0) begin errors++; $display("FAIL flush_then_mult: got lat=%0d %h_%h want %0d 0_2a", o_lat, o_hd, o_ld, MC); end
        @(negedge clk);
        flush = 1; req_valid = 1; req_op = MTLO; src_a = 32'h77;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_idle_ready: got %b want 0", req_ready); end
        @(posedge clk);
        #1 flush = 0; req_valid = 0;
        observe(3, 0, 0, 0);
        checks++; if (o_nval + o_nbusy !== 0) begin errors++; $display("FAIL flush_idle_accept: got valid=%0d busy=%0d want 0 0", o_nval, o_nbusy); end
        issue(MULT, 32'd3, 32'd3, 0, 0);
        observe(MC + 2, MC, 0, 0);
        checks++; if (o_nval !== 0) begin errors++; $display("FAIL flush_done_suppress: got %0d want 0", o_nval); end
    endtask

    task automatic test_reset_mid();
        issue(DIV, 32'd1000, 32'd3, 0, 0);
        observe(40, 0, 20, 20);
        checks++; if (o_ev_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", o_ev_busy); end
        checks++; if (o_ev_rdy !== 1'b0) begin errors++; $display("FAIL rstmid_ready_during: got %b want 0", o_ev_rdy); end
        checks++; if (o_nval !== 0) begin errors++; $display("FAIL rstmid_nowrite: got %0d want 0", o_nval); end
        checks++; if (o_rdy !== 21) begin errors++; $display("FAIL rstmid_ready_after: got %0d want 21", o_rdy); end
    endtask

    task automatic test_back_to_back();
        issue(MTLO, 32'h1, 0, 0, 0);
        req_op = MULT; src_a = 32'd3; src_b = 32'd5; req_valid = 1;
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 1'b0 || lo_req.valid !== 1'b1) begin errors++; $display("FAIL b2b_done_cycle: got ready=%b lo_valid=%b want 0 1", req_ready, lo_req.valid); end
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", req_ready); end
        @(posedge clk);
        #1 req_valid = 0;
        observe(MC + 2, 0, 0, 0);
        checks++; if (o_lat !== MC || o_ld !== 32'd15) begin errors++; $display("FAIL b2b_mult: got lat=%0d lo=%h want %0d 0000000f", o_lat, o_ld, MC); end
    endtask

    task automatic test_random();
        muldiv_op_t  op;
        logic [31:0] a, b, h, l, eh, el;
        logic        wh, wl;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            op = muldiv_op_t'($urandom_range(0, 9));
            a = pick(); b = pick(); h = $urandom; l = $urandom;
            model(op, a, b, h, l, wh, wl, eh, el, lat);
            issue(op, a, b, h, l);
            observe(lat + 3, 0, 0, 0);
            checks++; if (issue_rdy !== 1'b1) begin errors++; $display("FAIL rand%0d_%s_ready: got %b want 1", i, op.name(), issue_rdy); end
            checks++; if (o_nval !== int'(wh | wl)) begin errors++; $display("FAIL rand%0d_%s_valid_cycles: got %0d want %0d", i, op.name(), o_nval, int'(wh | wl)); end
            checks++; if ({o_hv, o_lv} !== {wh, wl}) begin errors++; $display("FAIL rand%0d_%s_valids: got %b%b want %b%b", i, op.name(), o_hv, o_lv, wh, wl); end
            if (wh | wl) begin
                checks++; if (o_lat !== lat) begin errors++; $display("FAIL rand%0d_%s_latency: got %0d want %0d", i, op.name(), o_lat, lat); end
            end
            if (wh) begin
                checks++; if (o_hd !== eh) begin errors++; $display("FAIL rand%0d_%s_hi a=%h b=%h: got %h want %h", i, op.name(), a, b, o_hd, eh); end
            end
            if (wl) begin
                checks++; if (o_ld !== el) begin errors++; $display("FAIL rand%0d_%s_lo a=%h b=%h: got %h want %h", i, op.name(), a, b, o_ld, el); end
            end
            checks++; if (o_nbusy !== lat) begin errors++; $display("FAIL rand%0d_%s_busy: got %0d want %0d", i, op.name(), o_nbusy, lat); end
            checks++; if (o_rdy !== lat + 1) begin errors++; $display("FAIL rand%0d_%s_ready_again: got %0d want %0d", i, op.name(), o_rdy, lat + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_move();
        test_accum();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 3, multiply latency in cycles from acceptance to HI/LO write; legal range 1..8.
REQ-002 SHALL have ports: clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have: req_valid  input  1  operation offered.
REQ-005 SHALL have: req_ready  output  1  operation accepted this cycle when high with req_valid.
REQ-006 SHALL have: req_op  input  muldiv_op_t  MULT, MULTU, DIV, DIVU, MTHI, MTLO, MADD, MADDU, MSUB, MSUBU.
REQ-007 SHALL have: src_a, src_b  input  32 each  operands (rs, rt); MTHI/MTLO use src_a.
REQ-008 SHALL have: hi_in, lo_in  input  32 each  current HI/LO, for accumulate ops.
REQ-009 SHALL have: flush  input  1  abort the in-flight operation.
REQ-010 SHALL have: busy  output  1  state not IDLE.
REQ-011 SHALL have: hi_req, lo_req  output  hilo_write_req  valid+data write requests to the HI/LO register file.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, DONE; req_ready = (state==IDLE) && !flush.
REQ-013 On acceptance SHALL latch op, operands, hi_in and lo_in; later input changes SHALL have no effect.
REQ-014 MTHI/MTLO: IDLE->DONE; write is hi_req or lo_req only, with data src_a, on the cycle after acceptance.
REQ-015 MULT/MULTU: IDLE->MUL; down-counter loaded with MUL_CYCLES-1; DONE entered so writes appear exactly MUL_CYCLES cycles after acceptance; MUL_CYCLES=1 goes straight to DONE.
REQ-016 Product SHALL be full 64-bit, signed or unsigned per op; hi=product[63:32], lo=product[31:0].
REQ-017 DIV/DIVU: IDLE->DIV; 32 iterations, one per cycle, then DONE; writes appear 33 cycles after acceptance.
REQ-018 Signed divide SHALL truncate toward zero; remainder (hi) takes dividend sign; quotient in lo.
REQ-019 Divide by zero SHALL give lo=0xFFFFFFFF, hi=src_a, signed or unsigned.
REQ-020 0x80000000 / 0xFFFFFFFF signed SHALL give lo=0x80000000, hi=0.
REQ-021 In DONE, both hi_req.valid and lo_req.valid SHALL be high for exactly one cycle for mult/div/accumulate ops; DONE->IDLE unconditionally.
REQ-022 Write-request valids SHALL be low in every state other than DONE; data is don't-care when valid is low.
REQ-023 flush SHALL force next state IDLE from any state; flush during DONE SHALL suppress both write valids that cycle.
REQ-024 flush with req_valid in IDLE SHALL accept nothing.
REQ-025 Earliest back-to-back acceptance is the cycle after DONE.

Reset
REQ-026 reset SHALL force IDLE and clear counters and latched operands; during reset and the first cycle after it, busy=0, valids=0, and req_ready=1 only after reset deasserts.
REQ-027 reset mid-operation SHALL abandon the operation with no write; reset SHALL take priority over flush and req_valid.

Configuration
REQ-028 Macro MULDIV_MADD_EN: when defined, MADD/MADDU/MSUB/MSUBU SHALL follow MULT timing with result {hi_in,lo_in} +/- product, modulo 2^64.
REQ-029 Without MULDIV_MADD_EN, accumulate ops SHALL be accepted, go IDLE->DONE in one cycle, and assert no write valid; no accumulate adder is instantiated.

Structure
REQ-030 muldiv_op_t and the existing hilo_write_req type SHALL live in package common; DIV_ITERS=32 is a package constant.
REQ-031 Iterative restoring divider SHALL be sub-module div_iter: start, operand magnitudes, quotient/remainder out, done after 32 cycles; sign fix-up stays in muldiv_ctrl.

Verification
REQ-032 MULT 0xFFFFFFFF x 2 (MUL_CYCLES=3) -> at cycle +3 hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU same operands -> hi=0x1, lo=0xFFFFFFFE.
REQ-033 DIV -7 / 2 -> at cycle +33 lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=7.
REQ-034 MTLO src_a=0x1234 -> next cycle lo_req valid with 0x1234, hi_req.valid=0; busy=1 for one cycle.
REQ-035 DIV accepted, flush at cycle +10 -> no write valid ever; req_ready=1 at cycle +11; new MULT completes normally.
REQ-036 With MULDIV_MADD_EN: hi_in=0, lo_in=0xFFFFFFFF, MADDU 1 x 1 -> hi=1, lo=0; without the macro -> no write, busy for 1 cycle.
REQ-037 reset asserted at cycle +20 of DIV -> no write; busy=0 during reset cycle; req_ready=1 after deassert.
